// File: rtl/mmio_pkg.sv
// Shared types and constants for the AXI4-Lite to MMIO slot bridge.
package mmio_pkg;

  localparam int unsigned SLOT_DATA_W = 32;
  localparam int unsigned STRB_W      = SLOT_DATA_W / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACC,
    ST_WR_ACC,
    ST_RD_RESP,
    ST_WR_RESP
  } bridge_state_e;

  // Decode error outranks slave error when a slot reports both.
  function automatic axi_resp_e done_resp(input logic slv, input logic dec);
    if (dec) return RESP_DECERR;
    if (slv) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/mmio_wr_collect.sv
// Collects AXI write address and write data independently; holds them until the B handshake.
module mmio_wr_collect
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   awvalid,
  input  logic [ADDR_W-1:0]      awaddr,
  output logic                   awready,
  input  logic                   wvalid,
  input  logic [SLOT_DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0]      wstrb,
  output logic                   wready,
  input  logic                   clear,
  output logic [ADDR_W-1:0]      addr,
  output logic [SLOT_DATA_W-1:0] data,
  output logic [STRB_W-1:0]      strb,
  output logic                   aw_have,
  output logic                   w_have
);

  // Ready is a one-cycle pulse; a latched channel stays closed until clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      addr    <= '0;
      data    <= '0;
      strb    <= '0;
      aw_have <= 1'b0;
      w_have  <= 1'b0;
    end else begin
      awready <= awvalid && !awready && !aw_have;
      wready  <= wvalid && !wready && !w_have;
      if (awvalid && awready) begin
        aw_have <= 1'b1;
        addr    <= awaddr;
      end
      if (wvalid && wready) begin
        w_have <= 1'b1;
        data   <= wdata;
        strb   <= wstrb;
      end
      if (clear) begin
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_mmio_slot_bridge.sv
// AXI4-Lite slave front end driving a one-hot MMIO slot bus, one access in flight at a time.
module axi_mmio_slot_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned           NUM_SLOTS      = 16,
  parameter int unsigned           REG_AW         = 4,
  parameter int unsigned           ADDR_W         = 10,
  parameter logic [NUM_SLOTS-1:0]  POPULATED      = {{(NUM_SLOTS-1){1'b0}}, 1'b1},
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic                             S_AXI_awvalid,
  output logic                             S_AXI_awready,
  input  logic [ADDR_W-1:0]                S_AXI_awaddr,
  input  logic [2:0]                       S_AXI_awprot,
  input  logic                             S_AXI_wvalid,
  output logic                             S_AXI_wready,
  input  logic [31:0]                      S_AXI_wdata,
  input  logic [3:0]                       S_AXI_wstrb,
  output logic                             S_AXI_bvalid,
  input  logic                             S_AXI_bready,
  output logic [1:0]                       S_AXI_bresp,
  input  logic                             S_AXI_arvalid,
  output logic                             S_AXI_arready,
  input  logic [ADDR_W-1:0]                S_AXI_araddr,
  input  logic [2:0]                       S_AXI_arprot,
  output logic                             S_AXI_rvalid,
  input  logic                             S_AXI_rready,
  output logic [31:0]                      S_AXI_rdata,
  output logic [1:0]                       S_AXI_rresp,
  output logic [NUM_SLOTS-1:0]             slot_chip_select,
  output logic [NUM_SLOTS-1:0]             slot_read,
  output logic [NUM_SLOTS-1:0]             slot_write,
  output logic [NUM_SLOTS*REG_AW-1:0]      slot_reg_addr,
  output logic [NUM_SLOTS*SLOT_DATA_W-1:0] slot_wr_data,
  input  logic [NUM_SLOTS*SLOT_DATA_W-1:0] slot_rd_data,
  input  logic [NUM_SLOTS-1:0]             slot_wr_done,
  input  logic [NUM_SLOTS-1:0]             slot_rd_done,
  input  logic [NUM_SLOTS-1:0]             slot_idle,
  input  logic [NUM_SLOTS-1:0]             slot_slave_error,
  input  logic [NUM_SLOTS-1:0]             slot_decode_error,
  output logic                             timeout_pulse,
  output logic [$clog2(NUM_SLOTS)-1:0]     timeout_slot
);

  localparam int unsigned SLOT_W  = $clog2(NUM_SLOTS);
  localparam int unsigned TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [NUM_SLOTS-1:0] ONE_HOT0 = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0]      wr_addr;
  logic [SLOT_DATA_W-1:0] wr_data;
  logic [STRB_W-1:0]      wr_strb;
  logic                   aw_have;
  logic                   w_have;
  logic                   b_done_c;

  bridge_state_e          state_q, state_d;
  logic                   last_rd_q, last_rd_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [REG_AW-1:0]      reg_q, reg_d;
  logic                   active_q, active_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [SLOT_DATA_W-1:0] rdata_q, rdata_d;
  axi_resp_e              rresp_q, rresp_d;
  logic                   bvalid_q, bvalid_d;
  axi_resp_e              bresp_q, bresp_d;
  logic [NUM_SLOTS-1:0]   cs_q, cs_d;
  logic [NUM_SLOTS-1:0]   rd_stb_q, rd_stb_d;
  logic [NUM_SLOTS-1:0]   wr_stb_q, wr_stb_d;
  logic                   to_pulse_q, to_pulse_d;
  logic [SLOT_W-1:0]      to_slot_q, to_slot_d;

  logic                   is_rd;
  logic                   sel_done;
  logic                   timeout_hit;
  logic [NUM_SLOTS-1:0]   sel_onehot;
  logic [SLOT_DATA_W-1:0] sel_data;
  logic                   fin;
  axi_resp_e              fin_resp;
  logic [SLOT_DATA_W-1:0] fin_data;

  assign b_done_c = (state_q == ST_WR_RESP) && S_AXI_bready;

  mmio_wr_collect #(.ADDR_W(ADDR_W)) u_wr_collect (
    .clk     (clk),
    .arst_n  (arst_n),
    .awvalid (S_AXI_awvalid),
    .awaddr  (S_AXI_awaddr),
    .awready (S_AXI_awready),
    .wvalid  (S_AXI_wvalid),
    .wdata   (S_AXI_wdata),
    .wstrb   (S_AXI_wstrb),
    .wready  (S_AXI_wready),
    .clear   (b_done_c),
    .addr    (wr_addr),
    .data    (wr_data),
    .strb    (wr_strb),
    .aw_have (aw_have),
    .w_have  (w_have)
  );

  assign is_rd       = (state_q == ST_RD_ACC);
  assign sel_done    = is_rd ? slot_rd_done[slot_q] : slot_wr_done[slot_q];
  assign sel_onehot  = ONE_HOT0 << slot_q;
  assign sel_data    = slot_rd_data[SLOT_DATA_W*int'(slot_q) +: SLOT_DATA_W];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TO_LAST));

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      last_rd_q  <= 1'b0;
      slot_q     <= '0;
      reg_q      <= '0;
      active_q   <= 1'b0;
      timer_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      cs_q       <= '0;
      rd_stb_q   <= '0;
      wr_stb_q   <= '0;
      to_pulse_q <= 1'b0;
      to_slot_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_rd_q  <= last_rd_d;
      slot_q     <= slot_d;
      reg_q      <= reg_d;
      active_q   <= active_d;
      timer_q    <= timer_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      cs_q       <= cs_d;
      rd_stb_q   <= rd_stb_d;
      wr_stb_q   <= wr_stb_d;
      to_pulse_q <= to_pulse_d;
      to_slot_q  <= to_slot_d;
    end
  end

  // Next state, arbitration, slot access sequencing and response capture
  always_comb begin
    state_d    = state_q;
    last_rd_d  = last_rd_q;
    slot_d     = slot_q;
    reg_d      = reg_q;
    active_d   = active_q;
    timer_d    = timer_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    cs_d       = cs_q;
    rd_stb_d   = rd_stb_q;
    wr_stb_d   = wr_stb_q;
    to_pulse_d = 1'b0;
    to_slot_d  = to_slot_q;
    fin        = 1'b0;
    fin_resp   = RESP_OKAY;
    fin_data   = '0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the read goes only if the write won last time.
        if (S_AXI_arvalid && !(aw_have && w_have && last_rd_q)) begin
          state_d   = ST_RD_ACC;
          arready_d = 1'b1;
          last_rd_d = 1'b1;
          slot_d    = S_AXI_araddr[ADDR_W-1 -: SLOT_W];
          reg_d     = S_AXI_araddr[REG_AW+1:2];
        end else if (aw_have && w_have) begin
          state_d   = ST_WR_ACC;
          last_rd_d = 1'b0;
          slot_d    = wr_addr[ADDR_W-1 -: SLOT_W];
          reg_d     = wr_addr[REG_AW+1:2];
        end
      end
      ST_RD_ACC, ST_WR_ACC: begin
        if (!active_q) begin
          if (!POPULATED[slot_q]) begin
            fin      = 1'b1;
            fin_resp = RESP_DECERR;
          end else if (!is_rd && (wr_strb != {STRB_W{1'b1}})) begin
            fin      = 1'b1;
            fin_resp = RESP_SLVERR;
          end else begin
            active_d = 1'b1;
            timer_d  = '0;
            cs_d     = sel_onehot;
            if (is_rd) rd_stb_d = sel_onehot;
            else       wr_stb_d = sel_onehot;
          end
        end else if (sel_done) begin
          fin      = 1'b1;
          fin_resp = done_resp(slot_slave_error[slot_q], slot_decode_error[slot_q]);
          fin_data = sel_data;
        end else if (timeout_hit) begin
          fin        = 1'b1;
          fin_resp   = RESP_SLVERR;
          to_pulse_d = 1'b1;
          to_slot_d  = slot_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RD_RESP: begin
        if (S_AXI_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_WR_RESP: begin
        if (S_AXI_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      active_d = 1'b0;
      cs_d     = '0;
      rd_stb_d = '0;
      wr_stb_d = '0;
      if (is_rd) begin
        rvalid_d = 1'b1;
        rresp_d  = fin_resp;
        rdata_d  = fin_data;
        state_d  = ST_RD_RESP;
      end else begin
        bvalid_d = 1'b1;
        bresp_d  = fin_resp;
        state_d  = ST_WR_RESP;
      end
    end
  end

  assign S_AXI_arready    = arready_q;
  assign S_AXI_rvalid     = rvalid_q;
  assign S_AXI_rdata      = rdata_q;
  assign S_AXI_rresp      = rresp_q;
  assign S_AXI_bvalid     = bvalid_q;
  assign S_AXI_bresp      = bresp_q;
  assign slot_chip_select = cs_q;
  assign slot_read        = rd_stb_q;
  assign slot_write       = wr_stb_q;
  assign slot_reg_addr    = {NUM_SLOTS{reg_q}};
  assign slot_wr_data     = {NUM_SLOTS{wr_data}};
  assign timeout_pulse    = to_pulse_q;
  assign timeout_slot     = to_slot_q;

  // Protection bits, byte offset and slot idle status carry no function here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_araddr[1:0], wr_addr[1:0], slot_idle};

endmodule

// File: tb/tb_axi_mmio_slot_bridge.sv
// Scoreboard bench for axi_mmio_slot_bridge: directed AXI traffic against a simple slot responder.
module tb_axi_mmio_slot_bridge;

  localparam int NS = 16;
  localparam int RA = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic arst_n;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NS-1:0] chip_select, slot_read, slot_write;
  logic [NS*RA-1:0] slot_reg_addr;
  logic [NS*32-1:0] slot_wr_data, slot_rd_data;
  logic [NS-1:0] wr_done, rd_done, slv_err, dec_err;
  logic timeout_pulse;
  logic [3:0] timeout_slot;

  always #5 clk = ~clk;

  axi_mmio_slot_bridge #(
    .NUM_SLOTS(NS), .REG_AW(RA), .ADDR_W(AW), .POPULATED(16'h0003), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .S_AXI_awvalid(awvalid), .S_AXI_awready(awready), .S_AXI_awaddr(awaddr), .S_AXI_awprot(3'b000),
    .S_AXI_wvalid(wvalid), .S_AXI_wready(wready), .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb),
    .S_AXI_bvalid(bvalid), .S_AXI_bready(bready), .S_AXI_bresp(bresp),
    .S_AXI_arvalid(arvalid), .S_AXI_arready(arready), .S_AXI_araddr(araddr), .S_AXI_arprot(3'b000),
    .S_AXI_rvalid(rvalid), .S_AXI_rready(rready), .S_AXI_rdata(rdata), .S_AXI_rresp(rresp),
    .slot_chip_select(chip_select), .slot_read(slot_read), .slot_write(slot_write),
    .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data), .slot_rd_data(slot_rd_data),
    .slot_wr_done(wr_done), .slot_rd_done(rd_done), .slot_idle({NS{1'b1}}),
    .slot_slave_error(slv_err), .slot_decode_error(dec_err),
    .timeout_pulse(timeout_pulse), .timeout_slot(timeout_slot)
  );

  typedef struct { logic [1:0] resp; logic [31:0] data; } resp_t;
  typedef struct { bit wr; int slot; int rg; logic [31:0] data; int len; } acc_t;

  resp_t exp_r[$];
  resp_t exp_b[$];
  acc_t  exp_acc[$];

  int errors = 0;
  int checks = 0;
  int done_delay = 1;
  bit err_slv = 0, err_dec = 0;
  int pulses = 0;
  bit acc_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or not seen at %0t", name, $time);
  endtask

  function automatic logic [31:0] fdata(input int s, input int r);
    if (s == 0 && r == 3) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(s << 8) | 32'(r);
  endfunction

  function automatic logic [AW-1:0] addr_of(input int s, input int r);
    return AW'(s * 64 + r * 4);
  endfunction

  always_comb begin
    for (int s = 0; s < NS; s++)
      slot_rd_data[s*32 +: 32] = fdata(s, int'(slot_reg_addr[s*RA +: RA]));
  end

  // Slot responder: done after done_delay strobe cycles; done_delay 0 never answers.
  initial begin
    int cnt [NS];
    for (int s = 0; s < NS; s++) cnt[s] = 0;
    rd_done = '0; wr_done = '0; slv_err = '0; dec_err = '0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < NS; s++) begin
        if (slot_read[s] === 1'b1 || slot_write[s] === 1'b1) begin
          cnt[s]++;
          if (done_delay != 0 && cnt[s] >= done_delay) begin
            rd_done[s] = slot_read[s];
            wr_done[s] = slot_write[s];
            slv_err[s] = err_slv;
            dec_err[s] = err_dec;
          end
        end else begin
          cnt[s] = 0;
          rd_done[s] = 1'b0; wr_done[s] = 1'b0; slv_err[s] = 1'b0; dec_err[s] = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected responses and slot accesses as the DUT presents them.
  initial begin
    bit r_stall = 0, b_stall = 0;
    logic [31:0] r_prev_data;
    logic [1:0] r_prev_resp, b_prev_resp;
    logic [NS-1:0] acc_stb, stb;
    int acc_len = 0, acc_exp_len = 0, sidx;
    resp_t e;
    acc_t ea;
    forever begin
      @(negedge clk);
      if (arst_n !== 1'b1) begin
        r_stall = 0; b_stall = 0; acc_on = 0;
        continue;
      end
      if (r_stall) begin
        chk("r_hold_valid", 64'(rvalid), 64'd1);
        chk("r_hold_data", 64'(rdata), 64'(r_prev_data));
        chk("r_hold_resp", 64'(rresp), 64'(r_prev_resp));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) bad("r_unexpected");
        else begin
          e = exp_r.pop_front();
          chk("rresp", 64'(rresp), 64'(e.resp));
          chk("rdata", 64'(rdata), 64'(e.data));
        end
      end
      r_stall = rvalid && !rready; r_prev_data = rdata; r_prev_resp = rresp;
      if (b_stall) chk("b_hold_resp", 64'(bresp), 64'(b_prev_resp));
      if (bvalid && bready) begin
        if (exp_b.size() == 0) bad("b_unexpected");
        else begin
          e = exp_b.pop_front();
          chk("bresp", 64'(bresp), 64'(e.resp));
        end
      end
      b_stall = bvalid && !bready; b_prev_resp = bresp;

      stb = slot_read | slot_write;
      if (stb != 0 && !acc_on) begin
        acc_on = 1; acc_len = 1; acc_stb = stb; sidx = 0;
        for (int s = NS - 1; s >= 0; s--) if (stb[s]) sidx = s;
        chk("acc_onehot", 64'($onehot(stb)), 64'd1);
        chk("acc_cs", 64'(chip_select), 64'(stb));
        if (exp_acc.size() == 0) begin
          bad("acc_unexpected");
          acc_exp_len = 0;
        end else begin
          ea = exp_acc.pop_front();
          acc_exp_len = ea.len;
          chk("acc_kind_wr", 64'(slot_write != 0), 64'(ea.wr));
          chk("acc_slot", 64'(sidx), 64'(ea.slot));
          chk("acc_reg", 64'(slot_reg_addr[sidx*RA +: RA]), 64'(ea.rg));
          if (ea.wr) chk("acc_wdata", 64'(slot_wr_data[sidx*32 +: 32]), 64'(ea.data));
        end
      end else if (stb != 0) begin
        acc_len++;
        chk("acc_stable", 64'(stb), 64'(acc_stb));
      end else if (acc_on) begin
        acc_on = 0;
        chk("acc_len", 64'(acc_len), 64'(acc_exp_len));
        chk("acc_cs_drop", 64'(chip_select), 64'd0);
      end
      if (timeout_pulse) pulses++;
    end
  end

  task automatic ar(input logic [AW-1:0] a);
    int n = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (!arready) bad("ar_handshake_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic aw(input logic [AW-1:0] a);
    int n = 0;
    @(posedge clk); #1;
    awaddr = a; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) bad("aw_handshake_timeout");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 100) begin @(negedge clk); n++; end
    if (!wready) bad("w_handshake_timeout");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (n < 300 && !(exp_r.size() == 0 && exp_b.size() == 0 && exp_acc.size() == 0 &&
                        !acc_on && !rvalid && !bvalid && !arvalid && !awvalid && !wvalid)) begin
      @(negedge clk); n++;
    end
    if (n >= 300) bad("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic push_acc(input bit wr, input int s, input int r, input logic [31:0] d, input int len);
    acc_t a;
    a.wr = wr; a.slot = s; a.rg = r; a.data = d; a.len = len;
    exp_acc.push_back(a);
  endtask

  task automatic push_r(input logic [1:0] resp, input logic [31:0] d);
    resp_t e;
    e.resp = resp; e.data = d;
    exp_r.push_back(e);
  endtask

  task automatic push_b(input logic [1:0] resp);
    resp_t e;
    e.resp = resp; e.data = '0;
    exp_b.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_resps", 64'({rresp, bresp}), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_strobes", 64'({chip_select, slot_read, slot_write}), 64'd0);
    chk("rst_timeout", 64'({timeout_pulse, timeout_slot}), 64'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    // Read slot0 reg3
    done_delay = 2;
    push_acc(0, 0, 3, '0, 2); push_r(2'b00, 32'hDEADBEEF);
    ar(addr_of(0, 3));
    wait_idle();

    // W three cycles ahead of AW, full strobes, slot1
    done_delay = 1;
    push_acc(1, 1, 5, 32'h12345678, 1); push_b(2'b00);
    fork
      w(32'h12345678, 4'hF);
      begin repeat (3) @(posedge clk); aw(addr_of(1, 5)); end
    join
    wait_idle();

    // Unpopulated slot
    push_r(2'b11, 32'h0);
    ar(addr_of(5, 0));
    wait_idle();

    // Timeouts on slot0 then slot1
    done_delay = 0;
    push_acc(0, 0, 1, '0, 8); push_r(2'b10, 32'h0);
    ar(addr_of(0, 1));
    wait_idle();
    chk("timeout_slot_0", 64'(timeout_slot), 64'd0);
    chk("timeout_pulses_1", 64'(pulses), 64'd1);
    push_acc(0, 1, 2, '0, 8); push_r(2'b10, 32'h0);
    ar(addr_of(1, 2));
    wait_idle();
    chk("timeout_slot_1", 64'(timeout_slot), 64'd1);
    chk("timeout_pulses_2", 64'(pulses), 64'd2);

    // Slot-reported errors: slave error on read, decode+slave on write
    done_delay = 1; err_slv = 1;
    push_acc(0, 1, 7, '0, 1); push_r(2'b10, 32'hC0DE0107);
    ar(addr_of(1, 7));
    wait_idle();
    err_dec = 1;
    push_acc(1, 1, 9, 32'hCAFEF00D, 1); push_b(2'b11);
    fork
      aw(addr_of(1, 9));
      w(32'hCAFEF00D, 4'hF);
    join
    wait_idle();
    err_slv = 0; err_dec = 0;

    // Arbitration: read first after reset-order, then the write wins the next tie
    push_acc(0, 0, 2, '0, 1);
    push_acc(1, 1, 4, 32'hA5A5A5A5, 1);
    push_acc(0, 1, 6, '0, 1);
    push_r(2'b00, 32'hC0DE0002); push_r(2'b00, 32'hC0DE0106); push_b(2'b00);
    fork
      begin ar(addr_of(0, 2)); ar(addr_of(1, 6)); end
      aw(addr_of(1, 4));
      w(32'hA5A5A5A5, 4'hF);
    join
    wait_idle();

    // Partial write strobe is refused
    push_b(2'b10);
    fork
      aw(addr_of(1, 3));
      w(32'h11111111, 4'h3);
    join
    wait_idle();

    // R backpressure for 5 cycles
    rready = 1'b0;
    push_acc(0, 0, 3, '0, 1); push_r(2'b00, 32'hDEADBEEF);
    ar(addr_of(0, 3));
    begin
      int n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (!rvalid) bad("rvalid_wait_timeout");
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rready = 1'b1;
    wait_idle();

    chk("left_r", 64'(exp_r.size()), 64'd0);
    chk("left_b", 64'(exp_b.size()), 64'd0);
    chk("left_acc", 64'(exp_acc.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
